io_sync_filter: RTL and testbench
=================================

// Module: io_sync_filter
// PURPOSE
//   Parametrised multi-channel conditioner for asynchronous board inputs (UART RX, buttons).
//   Per channel: N-flop synchroniser, then a consecutive-sample glitch filter with registered
//   rise/fall strobes. Sits between board pins and the core (e.g. top.rx_i) in board wrappers.
//   Generalises the fixed 2-flop single-RX synchroniser to any channel count, depth and filter.
// PARAMETERS
//   NumCh        2       number of independent input channels (>=1)
//   SyncStages   2       synchroniser flops per channel (>=2)
//   FilterCycles 4       consecutive differing synced samples required to accept a change (>=1)
//   ResetVal     {NumCh{1'b1}}  per-channel reset/idle level (UART idle=1, BTN_N released=1)
//   BreakCycles  1800    low-time threshold for break detect (used only with IO_SYNC_FILTER_BREAK_EN)
// PORTS
//   clk_i    in   1      single clock; all logic on posedge
//   rst_i    in   1      asynchronous, active-high reset
//   async_i  in   NumCh  raw asynchronous inputs, one bit per channel
//   level_o  out  NumCh  filtered, synchronous level
//   rise_o   out  NumCh  1-cycle strobe: level_o went 0->1
//   fall_o   out  NumCh  1-cycle strobe: level_o went 1->0
//   break_o  out  NumCh  level_o held low >= BreakCycles (macro-dependent, see CONFIGURATION)
// BEHAVIOUR
//   Reset (async assert, any cycle incl. mid-filter): sync chain=ResetVal, level_o=ResetVal,
//     rise_o=fall_o=break_o=0, all counters=0. Released state takes effect at first clk_i edge.
//   Sync: chain shifts async_i through SyncStages flops; s = last stage. No logic between flops.
//   Filter counter cnt per channel, width $clog2(FilterCycles+1):
//     s==level_o           -> cnt<=0 (glitch discarded, no strobe)
//     s!=level_o, cnt<FilterCycles-1 -> cnt<=cnt+1
//     s!=level_o, cnt==FilterCycles-1 -> level_o<=s, cnt<=0, strobe for the new level
//   FilterCycles=1: level_o follows s one edge later (pure synchroniser + register).
//   Strobes are registered, asserted in the same cycle level_o first shows the new value,
//     exactly 1 cycle wide; rise_o & fall_o never both high for one channel.
//   Latency: stable async_i step -> level_o change = SyncStages+FilterCycles edges (+1 for
//     sampling phase). Pulse shorter than FilterCycles synced samples -> never visible.
//   Toggle back during count: cnt clears the cycle s matches level_o; counting restarts from 0.
//   Channels fully independent; simultaneous changes on several channels handled in parallel.
//   Counters never wrap: max value FilterCycles-1, then cleared.
// CONFIGURATION
//   IO_SYNC_FILTER_BREAK_EN defined: per-channel low counter, width $clog2(BreakCycles+1),
//     increments each cycle level_o==0, saturates at BreakCycles; break_o=1 while
//     counter==BreakCycles; counter and break_o clear the cycle after level_o returns to 1.
//   Undefined: no break counters synthesised; break_o tied to 0.
// TESTING
//   T1 reset: assert rst_i mid-count with async_i=0 -> level_o=ResetVal, strobes 0, cnt 0 at once.
//   T2 step: NumCh=2, FilterCycles=4, ch0 1->0 held -> fall_o[0] 1-cycle pulse 6(+1) edges
//      later, level_o[0]=0, ch1 outputs unchanged.
//   T3 glitch: ch0 low for 3 cycles then high -> level_o[0] stays 1, no strobe; 4 cycles -> fall.
//   T4 chatter: ch0 alternates 0/1 every 2 cycles for 100 cycles -> no strobe, cnt never >=3.
//   T5 parallel: both channels step 1->0 same cycle -> fall_o=2'b11 same cycle; then ch1
//      back to 1 -> rise_o=2'b10 only.
//   T6 break (macro on, BreakCycles=20): ch0 low 25 cycles -> break_o[0] rises 20 cycles after
//      fall_o[0], clears 1 cycle after rise_o[0]; macro off -> break_o==0 throughout.

Source files
------------

// File: rtl/io_sync_filter.sv
// Multi-channel input conditioner: N-flop synchroniser followed by a consecutive-sample glitch filter
// with registered rise/fall strobes. Define IO_SYNC_FILTER_BREAK_EN to add per-channel break (long-low) detection.
module io_sync_filter #(
    parameter int unsigned      NumCh        = 2,
    parameter int unsigned      SyncStages   = 2,
    parameter int unsigned      FilterCycles = 4,
    parameter logic [NumCh-1:0] ResetVal     = {NumCh{1'b1}},
    parameter int unsigned      BreakCycles  = 1800
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NumCh-1:0] async_i,
    output logic [NumCh-1:0] level_o,
    output logic [NumCh-1:0] rise_o,
    output logic [NumCh-1:0] fall_o,
    output logic [NumCh-1:0] break_o
);

    localparam int unsigned     CntW    = $clog2(FilterCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);

    if (NumCh < 1 || SyncStages < 2 || FilterCycles < 1 || BreakCycles < 1) begin : g_param_err
        $error("io_sync_filter: illegal parameter combination");
    end

    logic [NumCh-1:0] sync_r [SyncStages];
    logic [NumCh-1:0] synced_s;

    // Plain shift chain; nothing may sit between the flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < SyncStages; k++) begin
                sync_r[k] <= ResetVal;
            end
        end else begin
            sync_r[0] <= async_i;
            for (int k = 1; k < SyncStages; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    assign synced_s = sync_r[SyncStages-1];

    for (genvar i = 0; i < NumCh; i++) begin : g_ch
        logic [CntW-1:0] cnt_r;
        logic [CntW-1:0] cnt_s;
        logic            level_r;
        logic            level_s;
        logic            rise_r;
        logic            rise_s;
        logic            fall_r;
        logic            fall_s;

        // Accept a new level only after FilterCycles consecutive differing samples.
        always_comb begin
            cnt_s   = cnt_r;
            level_s = level_r;
            rise_s  = 1'b0;
            fall_s  = 1'b0;
            if (synced_s[i] != level_r) begin
                if (cnt_r == CntLast) begin
                    cnt_s   = {CntW{1'b0}};
                    level_s = synced_s[i];
                    rise_s  = synced_s[i];
                    fall_s  = ~synced_s[i];
                end else begin
                    cnt_s = cnt_r + CntW'(1);
                end
            end else begin
                cnt_s = {CntW{1'b0}};
            end
        end

        // Filter state and strobe registers.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_r   <= {CntW{1'b0}};
                level_r <= ResetVal[i];
                rise_r  <= 1'b0;
                fall_r  <= 1'b0;
            end else begin
                cnt_r   <= cnt_s;
                level_r <= level_s;
                rise_r  <= rise_s;
                fall_r  <= fall_s;
            end
        end

        assign level_o[i] = level_r;
        assign rise_o[i]  = rise_r;
        assign fall_o[i]  = fall_r;

`ifdef IO_SYNC_FILTER_BREAK_EN
        localparam int unsigned     BrkW   = $clog2(BreakCycles + 1);
        localparam logic [BrkW-1:0] BrkMax = BrkW'(BreakCycles);

        logic [BrkW-1:0] brk_cnt_r;
        logic [BrkW-1:0] brk_cnt_s;
        logic            brk_r;

        // Saturating low-time counter, cleared once the filtered level is back high.
        always_comb begin
            brk_cnt_s = brk_cnt_r;
            if (level_r == 1'b0) begin
                if (brk_cnt_r != BrkMax) begin
                    brk_cnt_s = brk_cnt_r + BrkW'(1);
                end else begin
                    brk_cnt_s = brk_cnt_r;
                end
            end else begin
                brk_cnt_s = {BrkW{1'b0}};
            end
        end

        // Break flag registered alongside the counter so it tracks counter==BreakCycles.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                brk_cnt_r <= {BrkW{1'b0}};
                brk_r     <= 1'b0;
            end else begin
                brk_cnt_r <= brk_cnt_s;
                brk_r     <= (brk_cnt_s == BrkMax);
            end
        end

        assign break_o[i] = brk_r;
`else
        assign break_o[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_io_sync_filter.sv
// Directed self-checking bench for io_sync_filter (NumCh=2, SyncStages=2, FilterCycles=4, BreakCycles=20).
module tb_io_sync_filter;

    logic       clk_i;
    logic       rst_i;
    logic [1:0] async_i;
    logic [1:0] level_o;
    logic [1:0] rise_o;
    logic [1:0] fall_o;
    logic [1:0] break_o;

    int total;
    int bad;

    io_sync_filter #(
        .NumCh       (2),
        .SyncStages  (2),
        .FilterCycles(4),
        .ResetVal    (2'b11),
        .BreakCycles (20)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .async_i(async_i),
        .level_o(level_o),
        .rise_o (rise_o),
        .fall_o (fall_o),
        .break_o(break_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        async_i = 2'b11;
        #2;
        total++;
        if (level_o !== 2'b11) begin bad++; $display("FAIL reset level got=%b exp=%b", level_o, 2'b11); end
        total++;
        if (rise_o !== 2'b00) begin bad++; $display("FAIL reset rise got=%b exp=%b", rise_o, 2'b00); end
        total++;
        if (fall_o !== 2'b00) begin bad++; $display("FAIL reset fall got=%b exp=%b", fall_o, 2'b00); end
        total++;
        if (break_o !== 2'b00) begin bad++; $display("FAIL reset break got=%b exp=%b", break_o, 2'b00); end
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            tick();
            total++;
            if (level_o !== 2'b11) begin bad++; $display("FAIL idle level t=%0d got=%b exp=%b", t, level_o, 2'b11); end
        end
    endtask

    task automatic test_step();
        logic [1:0] exp_level;
        logic [1:0] exp_edge;
        async_i = 2'b10;
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp_edge  = (t == 6) ? 2'b01 : 2'b00;
            exp_level = (t >= 6) ? 2'b10 : 2'b11;
            total++;
            if (fall_o !== exp_edge) begin bad++; $display("FAIL step fall t=%0d got=%b exp=%b", t, fall_o, exp_edge); end
            total++;
            if (rise_o !== 2'b00) begin bad++; $display("FAIL step rise t=%0d got=%b exp=%b", t, rise_o, 2'b00); end
            total++;
            if (level_o !== exp_level) begin bad++; $display("FAIL step level t=%0d got=%b exp=%b", t, level_o, exp_level); end
        end
        async_i = 2'b11;
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp_edge  = (t == 6) ? 2'b01 : 2'b00;
            exp_level = (t >= 6) ? 2'b11 : 2'b10;
            total++;
            if (rise_o !== exp_edge) begin bad++; $display("FAIL unstep rise t=%0d got=%b exp=%b", t, rise_o, exp_edge); end
            total++;
            if (fall_o !== 2'b00) begin bad++; $display("FAIL unstep fall t=%0d got=%b exp=%b", t, fall_o, 2'b00); end
            total++;
            if (level_o !== exp_level) begin bad++; $display("FAIL unstep level t=%0d got=%b exp=%b", t, level_o, exp_level); end
        end
    endtask

    task automatic test_glitch();
        logic [1:0] exp_level;
        logic [1:0] exp_fall;
        logic [1:0] exp_rise;
        // three low samples: rejected
        for (int t = 1; t <= 12; t++) begin
            async_i = (t <= 3) ? 2'b10 : 2'b11;
            tick();
            total++;
            if (level_o !== 2'b11) begin bad++; $display("FAIL glitch3 level t=%0d got=%b exp=%b", t, level_o, 2'b11); end
            total++;
            if ((rise_o | fall_o) !== 2'b00) begin bad++; $display("FAIL glitch3 strobe t=%0d got=%b exp=%b", t, rise_o | fall_o, 2'b00); end
        end
        // four low samples: accepted
        for (int t = 1; t <= 12; t++) begin
            async_i = (t <= 4) ? 2'b10 : 2'b11;
            tick();
            exp_level = (t >= 6 && t <= 9) ? 2'b10 : 2'b11;
            exp_fall  = (t == 6) ? 2'b01 : 2'b00;
            exp_rise  = (t == 10) ? 2'b01 : 2'b00;
            total++;
            if (level_o !== exp_level) begin bad++; $display("FAIL glitch4 level t=%0d got=%b exp=%b", t, level_o, exp_level); end
            total++;
            if (fall_o !== exp_fall) begin bad++; $display("FAIL glitch4 fall t=%0d got=%b exp=%b", t, fall_o, exp_fall); end
            total++;
            if (rise_o !== exp_rise) begin bad++; $display("FAIL glitch4 rise t=%0d got=%b exp=%b", t, rise_o, exp_rise); end
        end
    endtask

    task automatic test_chatter();
        for (int t = 1; t <= 108; t++) begin
            async_i = (t <= 100) ? {1'b1, (((t - 1) / 2) % 2) == 1} : 2'b11;
            tick();
            total++;
            if (level_o !== 2'b11) begin bad++; $display("FAIL chatter level t=%0d got=%b exp=%b", t, level_o, 2'b11); end
            total++;
            if ((rise_o | fall_o) !== 2'b00) begin bad++; $display("FAIL chatter strobe t=%0d got=%b exp=%b", t, rise_o | fall_o, 2'b00); end
        end
    endtask

    task automatic test_parallel();
        logic [1:0] exp_level;
        logic [1:0] exp_edge;
        async_i = 2'b00;
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp_edge  = (t == 6) ? 2'b11 : 2'b00;
            exp_level = (t >= 6) ? 2'b00 : 2'b11;
            total++;
            if (fall_o !== exp_edge) begin bad++; $display("FAIL par fall t=%0d got=%b exp=%b", t, fall_o, exp_edge); end
            total++;
            if (level_o !== exp_level) begin bad++; $display("FAIL par level t=%0d got=%b exp=%b", t, level_o, exp_level); end
        end
        async_i = 2'b10;
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp_edge  = (t == 6) ? 2'b10 : 2'b00;
            exp_level = (t >= 6) ? 2'b10 : 2'b00;
            total++;
            if (rise_o !== exp_edge) begin bad++; $display("FAIL par1 rise t=%0d got=%b exp=%b", t, rise_o, exp_edge); end
            total++;
            if (fall_o !== 2'b00) begin bad++; $display("FAIL par1 fall t=%0d got=%b exp=%b", t, fall_o, 2'b00); end
            total++;
            if (level_o !== exp_level) begin bad++; $display("FAIL par1 level t=%0d got=%b exp=%b", t, level_o, exp_level); end
        end
        async_i = 2'b11;
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp_edge = (t == 6) ? 2'b01 : 2'b00;
            total++;
            if (rise_o !== exp_edge) begin bad++; $display("FAIL par0 rise t=%0d got=%b exp=%b", t, rise_o, exp_edge); end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp_edge;
        async_i = 2'b00;
        tick();
        tick();
        tick();
        rst_i = 1'b1;
        #1;
        total++;
        if (level_o !== 2'b11) begin bad++; $display("FAIL midrst level got=%b exp=%b", level_o, 2'b11); end
        total++;
        if ((rise_o | fall_o) !== 2'b00) begin bad++; $display("FAIL midrst strobe got=%b exp=%b", rise_o | fall_o, 2'b00); end
        tick();
        rst_i = 1'b0;
        // a cleared counter means the fall lands exactly six edges after release
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp_edge = (t == 6) ? 2'b11 : 2'b00;
            total++;
            if (fall_o !== exp_edge) begin bad++; $display("FAIL midrst fall t=%0d got=%b exp=%b", t, fall_o, exp_edge); end
        end
        async_i = 2'b11;
        for (int t = 1; t <= 7; t++) begin
            tick();
        end
        total++;
        if (level_o !== 2'b11) begin bad++; $display("FAIL midrst restore got=%b exp=%b", level_o, 2'b11); end
    endtask

    task automatic test_break();
        logic [1:0] exp_level;
        logic [1:0] exp_brk;
        for (int t = 1; t <= 34; t++) begin
            async_i = (t <= 25) ? 2'b10 : 2'b11;
            tick();
            exp_level = (t >= 6 && t <= 30) ? 2'b10 : 2'b11;
`ifdef IO_SYNC_FILTER_BREAK_EN
            exp_brk = (t >= 26 && t <= 31) ? 2'b01 : 2'b00;
`else
            exp_brk = 2'b00;
`endif
            total++;
            if (level_o !== exp_level) begin bad++; $display("FAIL break level t=%0d got=%b exp=%b", t, level_o, exp_level); end
            total++;
            if (break_o !== exp_brk) begin bad++; $display("FAIL break flag t=%0d got=%b exp=%b", t, break_o, exp_brk); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_step();
        test_glitch();
        test_chatter();
        test_parallel();
        test_reset_mid();
        test_break();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
